// File: rtl/levelsync_filt_vec.sv
// Multi-channel level synchronizer for the clk_dest domain.
// Per channel: sync chain, optional glitch filter, registered edge pulses.
module levelsync_filt_vec #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter logic [WIDTH-1:0] SET_VALUE     = '1
) (
  input  logic             clk_dest,
  input  logic             rst_dest,
  input  logic [WIDTH-1:0] set_dest,
  input  logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] dest_data,
  output logic [WIDTH-1:0] dest_rise,
  output logic [WIDTH-1:0] dest_fall,
  output logic [WIDTH-1:0] dest_busy
);

  localparam int CW =
    (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FILT = CW'(FILTER_CYCLES);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [STAGES-1:0] s_q, s_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              data_q, data_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sync;

    assign sync = s_q[STAGES-1];

    always_comb begin
      s_d    = {s_q[STAGES-2:0], src_data[i]};
      cnt_d  = cnt_q;
      data_d = data_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (set_dest[i]) begin
        s_d    = {STAGES{SET_VALUE[i]}};
        data_d = SET_VALUE[i];
        cnt_d  = '0;
      end else if (sync == data_q) begin
        cnt_d  = '0;
      end else if (cnt_q < FILT) begin
        cnt_d  = cnt_q + CW'(1);
      end else begin
        // Filter satisfied: take the new level and flag its direction
        data_d = sync;
        cnt_d  = '0;
        rise_d = sync;
        fall_d = ~sync;
      end
    end

    always_ff @(posedge clk_dest) begin
      if (rst_dest) begin
        s_q    <= {STAGES{RESET_VALUE[i]}};
        cnt_q  <= '0;
        data_q <= RESET_VALUE[i];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s_q    <= s_d;
        cnt_q  <= cnt_d;
        data_q <= data_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign dest_data[i] = data_q;
    assign dest_rise[i] = rise_q;
    assign dest_fall[i] = fall_q;
    assign dest_busy[i] = |cnt_q;
  end

endmodule

// File: tb/tb_levelsync_filt_vec.sv
// Directed bench for levelsync_filt_vec.
// Three configurations: plain, filtered, and three-stage.
module tb_levelsync_filt_vec;
  logic clk;
  logic rst_a, rst_b, rst_c;
  logic [3:0] set_a, set_b, set_c;
  logic [3:0] src_a, src_b, src_c;
  logic [3:0] dat_a, ris_a, fal_a, bsy_a;
  logic [3:0] dat_b, ris_b, fal_b, bsy_b;
  logic [3:0] dat_c, ris_c, fal_c, bsy_c;
  int n_tests = 0;
  int n_fail  = 0;

  levelsync_filt_vec #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(0),
    .RESET_VALUE(4'b0000), .SET_VALUE(4'b1111)
  ) u_a (
    .clk_dest(clk), .rst_dest(rst_a), .set_dest(set_a),
    .src_data(src_a), .dest_data(dat_a), .dest_rise(ris_a),
    .dest_fall(fal_a), .dest_busy(bsy_a)
  );

  levelsync_filt_vec #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(3),
    .RESET_VALUE(4'b0000), .SET_VALUE(4'b1111)
  ) u_b (
    .clk_dest(clk), .rst_dest(rst_b), .set_dest(set_b),
    .src_data(src_b), .dest_data(dat_b), .dest_rise(ris_b),
    .dest_fall(fal_b), .dest_busy(bsy_b)
  );

  levelsync_filt_vec #(
    .WIDTH(4), .STAGES(3), .FILTER_CYCLES(0),
    .RESET_VALUE(4'b0000), .SET_VALUE(4'b1111)
  ) u_c (
    .clk_dest(clk), .rst_dest(rst_c), .set_dest(set_c),
    .src_data(src_c), .dest_data(dat_c), .dest_rise(ris_c),
    .dest_fall(fal_c), .dest_busy(bsy_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag,
                       input logic [3:0] d,
                       input logic [3:0] r,
                       input logic [3:0] f,
                       input logic [3:0] b);
    chk({tag, ".data"}, 32'(dat_b), 32'(d));
    chk({tag, ".rise"}, 32'(ris_b), 32'(r));
    chk({tag, ".fall"}, 32'(fal_b), 32'(f));
    chk({tag, ".busy"}, 32'(bsy_b), 32'(b));
  endtask

  initial begin
    logic [3:0] old_c, new_c;
    rst_a = 1; rst_b = 1; rst_c = 1;
    set_a = 0; set_b = 0; set_c = 0;
    src_a = 0; src_b = 0; src_c = 0;
    tick();
    tick();
    chk("rst.a.data", 32'(dat_a), 0);
    chk("rst.a.rise", 32'(ris_a), 0);
    chk("rst.a.fall", 32'(fal_a), 0);
    chk_b("rst.b", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("rst.c.data", 32'(dat_c), 0);
    chk("rst.c.busy", 32'(bsy_c), 0);
    rst_a = 0; rst_b = 0; rst_c = 0;

    // 1: plain path, latency STAGES+1
    src_a = 4'b0001;
    tick();
    chk("t1.e1.data", 32'(dat_a), 0);
    tick();
    chk("t1.e2.data", 32'(dat_a), 0);
    tick();
    chk("t1.e3.data", 32'(dat_a), 32'h1);
    chk("t1.e3.rise", 32'(ris_a), 32'h1);
    chk("t1.e3.busy", 32'(bsy_a), 0);
    tick();
    chk("t1.e4.rise", 32'(ris_a), 0);
    chk("t1.e4.data", 32'(dat_a), 32'h1);

    // 2: filtered, held level
    src_b = 4'b0010;
    tick(); chk_b("t2.e1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t2.e2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t2.e3", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); chk_b("t2.e4", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); chk_b("t2.e5", 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tick(); chk_b("t2.e6", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    tick(); chk_b("t2.e7", 4'b0010, 4'b0000, 4'b0000, 4'b0000);

    // 3: glitch of 3 cycles is rejected
    src_b = 4'b0110;
    tick(); chk_b("t3.e1", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t3.e2", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t3.e3", 4'b0010, 4'b0000, 4'b0000, 4'b0100);
    src_b = 4'b0010;
    tick(); chk_b("t3.e4", 4'b0010, 4'b0000, 4'b0000, 4'b0100);
    tick(); chk_b("t3.e5", 4'b0010, 4'b0000, 4'b0000, 4'b0100);
    tick(); chk_b("t3.e6", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t3.e7", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t3.e8", 4'b0010, 4'b0000, 4'b0000, 4'b0000);

    // 4a: set on plain config, then release
    set_a = 4'b0100;
    tick();
    chk("t4a.set.data", 32'(dat_a), 32'h5);
    chk("t4a.set.rise", 32'(ris_a), 0);
    chk("t4a.set.fall", 32'(fal_a), 0);
    set_a = 0;
    tick();
    chk("t4a.r1.data", 32'(dat_a), 32'h5);
    tick();
    chk("t4a.r2.data", 32'(dat_a), 32'h5);
    chk("t4a.r2.fall", 32'(fal_a), 0);
    tick();
    chk("t4a.r3.data", 32'(dat_a), 32'h1);
    chk("t4a.r3.fall", 32'(fal_a), 32'h4);
    chk("t4a.r3.rise", 32'(ris_a), 0);
    tick();
    chk("t4a.r4.fall", 32'(fal_a), 0);

    // 4b: set on filtered config, release latency 6
    set_b = 4'b0100;
    tick(); chk_b("t4b.set", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    set_b = 0;
    tick(); chk_b("t4b.r1", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t4b.r2", 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t4b.r3", 4'b0110, 4'b0000, 4'b0000, 4'b0100);
    tick(); chk_b("t4b.r4", 4'b0110, 4'b0000, 4'b0000, 4'b0100);
    tick(); chk_b("t4b.r5", 4'b0110, 4'b0000, 4'b0000, 4'b0100);
    tick(); chk_b("t4b.r6", 4'b0010, 4'b0000, 4'b0100, 4'b0000);
    tick(); chk_b("t4b.r7", 4'b0010, 4'b0000, 4'b0000, 4'b0000);

    // 5: reset and set together mid-count
    src_b = 4'b1010;
    tick(); tick(); tick(); tick();
    chk_b("t5.mid", 4'b0010, 4'b0000, 4'b0000, 4'b1000);
    rst_b = 1;
    set_b = 4'b1000;
    tick(); chk_b("t5.rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst_b = 0;
    set_b = 0;
    tick(); chk_b("t5.r1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t5.r2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_b("t5.r3", 4'b0000, 4'b0000, 4'b0000, 4'b1010);
    tick(); chk_b("t5.r4", 4'b0000, 4'b0000, 4'b0000, 4'b1010);
    tick(); chk_b("t5.r5", 4'b0000, 4'b0000, 4'b0000, 4'b1010);
    tick(); chk_b("t5.r6", 4'b1010, 4'b1010, 4'b0000, 4'b0000);

    // 6: three-stage chain, toggling every 8 cycles
    for (int k = 0; k < 4; k++) begin
      old_c = src_c;
      new_c = ~src_c;
      src_c = new_c;
      for (int j = 1; j <= 8; j++) begin
        tick();
        chk($sformatf("t6.k%0d.j%0d.data", k, j),
            32'(dat_c), 32'((j >= 4) ? new_c : old_c));
        chk($sformatf("t6.k%0d.j%0d.rise", k, j),
            32'(ris_c), 32'((j == 4) ? new_c : 4'b0000));
        chk($sformatf("t6.k%0d.j%0d.fall", k, j),
            32'(fal_c), 32'((j == 4) ? old_c : 4'b0000));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
